master_axi_stream_tx: RTL and testbench



---
 rtl/axis_pkg.sv | 19 +
 rtl/axis_tx_fifo.sv | 49 ++++
 rtl/master_axi_stream_tx.sv | 128 ++++++++++++
 tb/tb_master_axi_stream_tx.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types for the AXI4-Stream transmitter: the buffered beat and the packet FSM states.
// AXIS_N fixes the beat width; the top's n parameter must match it.
package axis_pkg;

    localparam int AXIS_N = 4;

    typedef struct packed {
        logic [8*AXIS_N-1:0] data;
        logic [AXIS_N-1:0]   keep;
        logic                last;
        logic                user;
    } beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

endpackage

// File: rtl/axis_tx_fifo.sv
// Synchronous FIFO of stream beats with extra-MSB pointers for full/empty detection.
// The head entry is presented combinationally on dout.
module axis_tx_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  beat_t din,
    input  logic  pop,
    output beat_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    beat_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/master_axi_stream_tx.sv
// AXI4-Stream master: FIFO-buffered local write port feeding a registered AXI-S output,
// with max-packet-length tlast forcing and packet completion counting.
module master_axi_stream_tx
    import axis_pkg::*;
#(
    parameter int   n       = AXIS_N,
    parameter int   DEPTH   = 8,
    parameter int   MAX_PKT = 32,
    parameter logic TID_V   = 1'b0,
    parameter logic TDEST_V = 1'b0
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           wr_en,
    input  logic [8*n-1:0] wr_data,
    input  logic [n-1:0]   wr_keep,
    input  logic           wr_last,
    input  logic           wr_user,
    output logic           wr_full,
    output logic           ovf_err,
    output logic           keep_err,
    output logic           tvalid,
    input  logic           tready,
    output logic [8*n-1:0] tdata,
    output logic [n-1:0]   tstrb,
    output logic [n-1:0]   tkeep,
    output logic           tlast,
    output logic           TID,
    output logic           TDEST,
    output logic           TUSER,
    output logic           pkt_done,
    output logic [15:0]    pkt_count
);

    localparam int CW = $clog2(MAX_PKT);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    beat_t     wr_beat;
    beat_t     head;
    logic      fifo_empty;
    logic      keep_ok;
    logic      push;
    logic      load;
    logic      load_last;
    logic      hs_last;
    logic [CW-1:0] beat_cnt;
    tx_state_t state_q;
    tx_state_t state_d;

    assign wr_beat.data = wr_data;
    assign wr_beat.keep = wr_keep;
    assign wr_beat.last = wr_last;
    assign wr_beat.user = wr_user;

    assign keep_ok   = |wr_keep;
    assign push      = wr_en && !wr_full && keep_ok;
    assign load      = (!tvalid || tready) && !fifo_empty;
    assign load_last = head.last || (beat_cnt == LAST_IDX);
    assign hs_last   = tvalid && tready && tlast;

    assign tstrb = tkeep;
    assign TID   = TID_V;
    assign TDEST = TDEST_V;

    axis_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .din   (wr_beat),
        .pop   (load),
        .dout  (head),
        .full  (wr_full),
        .empty (fifo_empty)
    );

    // Output register refills whenever the current beat is gone or absent.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid   <= 1'b0;
            tdata    <= '0;
            tkeep    <= '0;
            tlast    <= 1'b0;
            TUSER    <= 1'b0;
            beat_cnt <= '0;
        end else if (load) begin
            tvalid   <= 1'b1;
            tdata    <= head.data;
            tkeep    <= head.keep;
            tlast    <= load_last;
            TUSER    <= head.user;
            beat_cnt <= load_last ? '0 : beat_cnt + CNT_ONE;
        end else if (tready) begin
            tvalid   <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ovf_err   <= 1'b0;
            keep_err  <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_count <= '0;
        end else begin
            ovf_err  <= wr_en && wr_full;
            keep_err <= wr_en && !wr_full && !keep_ok;
            pkt_done <= hs_last;
            if (hs_last) pkt_count <= pkt_count + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (load && !load_last) state_d = ACTIVE;
            ACTIVE: if (load && load_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_master_axi_stream_tx.sv
// Scoreboard bench for master_axi_stream_tx: beats queued on accepted writes,
// popped and compared on each AXI-S handshake.
module tb_master_axi_stream_tx;
    import axis_pkg::*;

    localparam int DEPTH   = 8;
    localparam int MAX_PKT = 32;

    logic        aclk = 1'b0;
    logic        areset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_keep;
    logic        wr_last;
    logic        wr_user;
    logic        wr_full;
    logic        ovf_err;
    logic        keep_err;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        TID;
    logic        TDEST;
    logic        TUSER;
    logic        pkt_done;
    logic [15:0] pkt_count;

    always #5 aclk = ~aclk;

    master_axi_stream_tx #(
        .n       (4),
        .DEPTH   (DEPTH),
        .MAX_PKT (MAX_PKT),
        .TID_V   (1'b0),
        .TDEST_V (1'b0)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_keep   (wr_keep),
        .wr_last   (wr_last),
        .wr_user   (wr_user),
        .wr_full   (wr_full),
        .ovf_err   (ovf_err),
        .keep_err  (keep_err),
        .tvalid    (tvalid),
        .tready    (tready),
        .tdata     (tdata),
        .tstrb     (tstrb),
        .tkeep     (tkeep),
        .tlast     (tlast),
        .TID       (TID),
        .TDEST     (TDEST),
        .TUSER     (TUSER),
        .pkt_done  (pkt_done),
        .pkt_count (pkt_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } exp_t;

    exp_t        sb [$];
    exp_t        me;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          mcnt    = 0;
    int          acc_cnt = 0;
    int          hs_cnt  = 0;
    int          pd_cnt  = 0;
    int          exp_pc  = 0;
    int          exp_pd  = 0;
    logic        hold_v  = 1'b0;
    logic [42:0] h_vec;

    // Handshake monitor: scoreboard compare plus stall stability.
    always @(negedge aclk) begin
        if (areset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_cmp++;
                if ({tvalid, tdata, tkeep, tstrb, tlast, TUSER} !== h_vec) begin
                    n_bad++;
                    $display("FAIL hold_stable: got %h want %h",
                             {tvalid, tdata, tkeep, tstrb, tlast, TUSER}, h_vec);
                end
            end
            if (tvalid && tready) begin
                hs_cnt++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_extra_beat: got data %h want none", tdata);
                end else begin
                    me = sb.pop_front();
                    if ({tdata, tkeep, tstrb, tlast, TUSER} !==
                        {me.data, me.keep, me.keep, me.last, me.user}) begin
                        n_bad++;
                        $display("FAIL beat: got d=%h k=%h s=%h l=%b u=%b want d=%h k=%h l=%b u=%b",
                                 tdata, tkeep, tstrb, tlast, TUSER,
                                 me.data, me.keep, me.last, me.user);
                    end
                end
            end
            if (pkt_done) pd_cnt++;
            hold_v = tvalid && !tready;
            h_vec  = {tvalid, tdata, tkeep, tstrb, tlast, TUSER};
        end
    end

    task automatic tick(input int c);
        repeat (c) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic write_cycle(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u, input bit acc);
        exp_t e;
        wr_en   = 1'b1;
        wr_data = d;
        wr_keep = k;
        wr_last = l;
        wr_user = u;
        if (acc) begin
            e.data = d;
            e.keep = k;
            e.user = u;
            e.last = l || (mcnt == MAX_PKT - 1);
            mcnt   = e.last ? 0 : mcnt + 1;
            if (e.last) begin
                exp_pc++;
                exp_pd++;
            end
            sb.push_back(e);
            acc_cnt++;
        end
        @(posedge aclk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        tick(3);
        n_cmp++;
        if ({tvalid, wr_full, ovf_err, keep_err, pkt_done, pkt_count, tdata, tlast, TUSER} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b f=%b pc=%h d=%h want zeros",
                     tvalid, wr_full, pkt_count, tdata);
        end
        n_cmp++;
        if ({TID, TDEST} !== 2'b00) begin
            n_bad++;
            $display("FAIL tid_tdest: got %b want 00", {TID, TDEST});
        end
        areset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        int h0;
        int p0;
        tready = 1'b1;
        h0 = hs_cnt;
        p0 = pd_cnt;
        write_cycle(32'd1, 4'hF, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: got tvalid %b want 0", tvalid);
        end
        write_cycle(32'd2, 4'hF, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== 32'd1) begin
            n_bad++;
            $display("FAIL latency_first: got v=%b d=%h want v=1 d=1", tvalid, tdata);
        end
        write_cycle(32'd3, 4'hF, 1'b0, 1'b0, 1'b1);
        write_cycle(32'd4, 4'hF, 1'b1, 1'b0, 1'b1);
        tick(2);
        n_cmp++;
        if (hs_cnt - h0 !== 4) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d beats want 4", hs_cnt - h0);
        end
        tick(3);
        n_cmp++;
        if (pd_cnt - p0 !== 1 || pkt_count !== 16'(exp_pc)) begin
            n_bad++;
            $display("FAIL pkt_done_count: got pulses %0d count %0d want 1 / %0d",
                     pd_cnt - p0, pkt_count, exp_pc);
        end
        n_cmp++;
        if (tvalid !== 1'b0 || pkt_done !== 1'b0) begin
            n_bad++;
            $display("FAIL drained: got v=%b pd=%b want 0 0", tvalid, pkt_done);
        end
    endtask

    task automatic test_reset_mid;
        int h0;
        tready = 1'b0;
        write_cycle(32'h11, 4'hF, 1'b0, 1'b0, 1'b1);
        write_cycle(32'h12, 4'hF, 1'b0, 1'b0, 1'b1);
        write_cycle(32'h13, 4'hF, 1'b0, 1'b0, 1'b1);
        areset = 1'b1;
        tick(1);
        n_cmp++;
        if ({tvalid, wr_full, pkt_count, tlast} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got v=%b f=%b pc=%0d l=%b want 0 0 0 0",
                     tvalid, wr_full, pkt_count, tlast);
        end
        tick(2);
        areset = 1'b0;
        sb.delete();
        mcnt   = 0;
        exp_pc = 0;
        h0     = hs_cnt;
        tready = 1'b1;
        tick(4);
        n_cmp++;
        if (hs_cnt !== h0 || tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flush: got %0d beats v=%b want 0 0", hs_cnt - h0, tvalid);
        end
    endtask

    task automatic test_overflow;
        tready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            write_cycle(32'(i), (i <= 9) ? 4'hF : 4'h0, i == 9, 1'b0, i <= 9);
            if (i == 8) begin
                n_cmp++;
                if (wr_full !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_early: got %b want 0", wr_full);
                end
            end
            if (i == 9) begin
                n_cmp++;
                if (wr_full !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_set: got %b want 1", wr_full);
                end
            end
        end
        n_cmp++;
        if (ovf_err !== 1'b1 || keep_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_priority: got ovf=%b keep=%b want 1 0", ovf_err, keep_err);
        end
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== 32'd1) begin
            n_bad++;
            $display("FAIL stall_head: got v=%b d=%h want 1 1", tvalid, tdata);
        end
        tick(1);
        n_cmp++;
        if (ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_pulse: got %b want 0", ovf_err);
        end
        tready = 1'b1;
        tick(12);
        n_cmp++;
        if (sb.size() !== 0 || tvalid !== 1'b0 || pkt_count !== 16'(exp_pc)) begin
            n_bad++;
            $display("FAIL ovf_drain: got left %0d v=%b pc=%0d want 0 0 %0d",
                     sb.size(), tvalid, pkt_count, exp_pc);
        end
    endtask

    task automatic test_forced_last;
        tready = 1'b1;
        for (int i = 0; i < 40; i++)
            write_cycle(32'h100 + 32'(i), 4'hF, 1'b0, i[0], 1'b1);
        tick(4);
        n_cmp++;
        if (pkt_count !== 16'(exp_pc) || sb.size() !== 0) begin
            n_bad++;
            $display("FAIL forced_last: got pc=%0d left=%0d want %0d 0",
                     pkt_count, sb.size(), exp_pc);
        end
        write_cycle(32'hDEAD, 4'hF, 1'b1, 1'b0, 1'b1);
        tick(4);
    endtask

    task automatic test_keep;
        int h0;
        tready = 1'b0;
        h0 = hs_cnt;
        write_cycle(32'hBAD, 4'h0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (keep_err !== 1'b1 || ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL keep_err: got keep=%b ovf=%b want 1 0", keep_err, ovf_err);
        end
        tick(2);
        n_cmp++;
        if (keep_err !== 1'b0 || tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL keep_drop: got keep=%b v=%b want 0 0", keep_err, tvalid);
        end
        write_cycle(32'hA5A5, 4'h3, 1'b1, 1'b1, 1'b1);
        tick(1);
        n_cmp++;
        if (tvalid !== 1'b1 || tkeep !== 4'h3 || tstrb !== 4'h3) begin
            n_bad++;
            $display("FAIL keep_partial: got v=%b k=%h s=%h want 1 3 3", tvalid, tkeep, tstrb);
        end
        tready = 1'b1;
        tick(3);
        n_cmp++;
        if (hs_cnt - h0 !== 1) begin
            n_bad++;
            $display("FAIL keep_beats: got %0d want 1", hs_cnt - h0);
        end
    endtask

    task automatic test_random;
        int i;
        int cyc;
        int errs;
        int h0;
        i    = 0;
        cyc  = 0;
        errs = 0;
        h0   = hs_cnt;
        while ((i < 200 || sb.size() > 0) && cyc < 5000) begin
            tready = 1'($urandom_range(0, 1));
            if (i < 200 && (acc_cnt - hs_cnt) < DEPTH) begin
                write_cycle($urandom, 4'($urandom_range(1, 15)),
                            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'b1);
                i++;
            end else begin
                tick(1);
            end
            if (ovf_err || keep_err) errs++;
            cyc++;
        end
        tready = 1'b1;
        tick(3);
        n_cmp++;
        if (sb.size() !== 0 || hs_cnt - h0 !== 200) begin
            n_bad++;
            $display("FAIL random_stream: got %0d beats left %0d want 200 0",
                     hs_cnt - h0, sb.size());
        end
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL random_errs: got %0d want 0", errs);
        end
        n_cmp++;
        if (pd_cnt !== exp_pd || pkt_count !== 16'(exp_pc)) begin
            n_bad++;
            $display("FAIL random_pkts: got pd=%0d pc=%0d want %0d %0d",
                     pd_cnt, pkt_count, exp_pd, exp_pc);
        end
    endtask

    initial begin
        areset  = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_keep = '0;
        wr_last = 1'b0;
        wr_user = 1'b0;
        tready  = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_reset_mid();
        test_overflow();
        test_forced_last();
        test_keep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
